// File: rtl/c17_pattern_sequencer_pkg.sv
// Shared types, constants and the golden c17 reference for the pattern sequencer.
package c17_tpg_pkg;

    localparam int unsigned VEC_W = 5;
    localparam int unsigned RSP_W = 2;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Fibonacci taps for x^5 + x^3 + 1 (feedback from bits 4 and 2)
    localparam logic [VEC_W-1:0] LFSR_TAPS         = 5'b10100;
    localparam logic [VEC_W-1:0] LFSR_NONZERO_SEED = 5'h01;

    // First-failure record kept by the scoreboard
    typedef struct packed {
        logic             valid;
        logic [VEC_W-1:0] vec;
    } first_fail_t;

    // Reference c17 netlist; vec = {N1,N2,N3,N6,N7}, result = {N22,N23}
    function automatic logic [RSP_W-1:0] c17_golden(input logic [VEC_W-1:0] vec);
        logic n1, n2, n3, n6, n7;
        logic n10, n11, n16, n19;
        n1  = vec[4];
        n2  = vec[3];
        n3  = vec[2];
        n6  = vec[1];
        n7  = vec[0];
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

endpackage

// File: rtl/c17_pattern_sequencer_if.sv
// Host and CUT signal bundle of the c17 pattern sequencer.
interface c17_pattern_sequencer_if #(
    parameter int unsigned CNT_W = 6
);
    logic             start;
    logic             abort;
    logic             mode;
    logic [4:0]       seed;
    logic [4:0]       cut_in;
    logic [1:0]       cut_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             first_fail_valid;
    logic [4:0]       first_fail_vec;

    // Sequencer side
    modport slave (
        input  start, abort, mode, seed, cut_out,
        output cut_in, busy, done, mismatch_cnt, first_fail_valid, first_fail_vec
    );

    // Host/CUT side
    modport master (
        output start, abort, mode, seed, cut_out,
        input  cut_in, busy, done, mismatch_cnt, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/tpg_lfsr5.sv
// 5-bit pattern generator: binary up-counter or x^5+x^3+1 Fibonacci LFSR.
module tpg_lfsr5
    import c17_tpg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [VEC_W-1:0] seed,
    output logic [VEC_W-1:0] value
);

    logic             mode_q;
    logic [VEC_W-1:0] value_q;
    logic [VEC_W-1:0] seed_c;
    logic [VEC_W-1:0] next_c;

    // Load value and successor of the current value
    always_comb begin
        seed_c = (seed == '0) ? LFSR_NONZERO_SEED : seed;
        if (mode_q) begin
            next_c = {value_q[VEC_W-2:0], ^(value_q & LFSR_TAPS)};
        end else begin
            next_c = value_q + VEC_W'(1);
        end
    end

    // Mode is captured at load so a run cannot switch generators midway
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= 1'b0;
            value_q <= '0;
        end else if (load) begin
            mode_q  <= mode;
            value_q <= mode ? seed_c : '0;
        end else if (step) begin
            value_q <= next_c;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/c17_pattern_sequencer.sv
// Applies patterns to a c17 CUT, checks responses against the golden model and records failures.
module c17_pattern_sequencer
    import c17_tpg_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS  = 32,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    c17_pattern_sequencer_if.slave   bus
);

    // Index is widened when needed so a narrow result counter still allows a full run
    localparam int unsigned PAT_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam int unsigned IDX_W = (CNT_W > PAT_W) ? CNT_W : PAT_W;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_PATTERNS - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e            state_q;
    state_e            state_d;

    logic [VEC_W-1:0]  cut_in_q;
    logic [SET_W-1:0]  settle_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    first_fail_t       ff_q;
    logic              busy_q;
    logic              done_q;

    logic [VEC_W-1:0]  gen_value;
    logic              accept_c;
    logic              gen_step_c;
    logic              apply_c;
    logic              settle_c;
    logic              capture_c;
    logic              miss_c;
    logic              last_c;
    logic              busy_d;
    logic              done_d;

    assign last_c = (idx_q == LAST_IDX);

    // Pattern source
    tpg_lfsr5 u_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (accept_c),
        .step  (gen_step_c),
        .mode  (bus.mode),
        .seed  (bus.seed),
        .value (gen_value)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks everything outside IDLE
    always_comb begin
        state_d = state_q;
        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (bus.start) state_d = ST_APPLY;
                ST_APPLY:         state_d = ST_SETTLE;
                ST_SETTLE:        if (settle_q <= SET_W'(1)) state_d = ST_CAPTURE;
                ST_CAPTURE:       state_d = last_c ? ST_DONE : ST_APPLY;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath strobes and next values of the registered status outputs
    always_comb begin
        accept_c   = 1'b0;
        apply_c    = 1'b0;
        settle_c   = 1'b0;
        capture_c  = 1'b0;
        gen_step_c = 1'b0;
        miss_c     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        if (!bus.abort) begin
            case (state_q)
                ST_IDLE, ST_DONE: accept_c  = bus.start;
                ST_APPLY:         apply_c   = 1'b1;
                ST_SETTLE:        settle_c  = 1'b1;
                ST_CAPTURE: begin
                    capture_c  = 1'b1;
                    gen_step_c = ~last_c;
                    miss_c     = (bus.cut_out != c17_golden(cut_in_q));
                end
                default: ;
            endcase
        end
        busy_d = (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    // Stimulus, settle timer, pattern index and scoreboard registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cut_in_q <= '0;
            settle_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            ff_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (accept_c) begin
                idx_q <= '0;
                cnt_q <= '0;
                ff_q  <= '0;
            end
            if (apply_c) begin
                cut_in_q <= gen_value;
                settle_q <= SETTLE_LOAD;
            end
            if (settle_c) begin
                settle_q <= settle_q - SET_W'(1);
            end
            if (capture_c) begin
                if (miss_c) begin
                    if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
                    if (!ff_q.valid) ff_q <= '{valid: 1'b1, vec: cut_in_q};
                end
                if (!last_c) idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign bus.cut_in           = cut_in_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.mismatch_cnt     = cnt_q;
    assign bus.first_fail_valid = ff_q.valid;
    assign bus.first_fail_vec   = ff_q.vec;

endmodule
